// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder.
//   state_t       : FSM state encoding (IDLE / SHIFT / DONE)
//   DEFAULT_WIDTH : default operand/result width in bits
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the bit-serial adder.
//   start     : request pulse, accepted only while the adder is IDLE or DONE
//   a, b      : operands, captured on the accepted start edge
//   carry_in  : initial carry, captured on the accepted start edge
//   busy      : high while bits are being shifted through the full adder
//   done      : one-cycle completion pulse; sum/carry_out valid from then on
//   sum       : registered WIDTH-bit result
//   carry_out : registered final carry
//   state     : current FSM state, for observation only
//
// Handshake: a request transfers on a rising edge where start=1 and busy=0
// (busy acts as the inverse of ready). done is a valid strobe with no
// back-pressure; the result then stays held until the next completion.
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    state_t           state;

    modport master (
        output start, a, b, carry_in,
        input  busy, done, sum, carry_out, state
    );

    modport slave (
        input  start, a, b, carry_in,
        output busy, done, sum, carry_out, state
    );
endinterface

// File: rtl/full_adder.sv
// Single-bit full adder cell.
//   x, y      : addend bits
//   carry_in  : incoming carry
//   sum       : x ^ y ^ carry_in
//   carry_out : majority of the three inputs
module full_adder (
    input  logic x,
    input  logic y,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);
    assign sum       = x ^ y ^ carry_in;
    assign carry_out = (x & y) | (carry_in & (x ^ y));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder built around one full_adder cell, LSB first.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : serial_adder_if slave (start/a/b/carry_in in;
//           busy/done/sum/carry_out/state out)
// A request takes WIDTH shift cycles followed by a one-cycle DONE state; a
// new start in DONE restarts immediately so operations can run back to back.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             shift_en;
    logic             last_bit;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             c_ff;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             fa_sum;
    logic             fa_cout;

    full_adder u_fa (
        .x         (a_sr[0]),
        .y         (b_sr[0]),
        .carry_in  (c_ff),
        .sum       (fa_sum),
        .carry_out (fa_cout)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift_en  = 1'b0;
        last_bit  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // start is deliberately ignored here; the operation in
                // flight always runs to completion.
                shift_en = 1'b1;
                if (cnt == CNT_LAST) begin
                    last_bit  = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = ST_SHIFT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand shift registers, carry flip-flop, bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            c_ff   <= 1'b0;
            cnt    <= '0;
        end else if (load) begin
            a_sr   <= bus.a;
            b_sr   <= bus.b;
            res_sr <= '0;
            c_ff   <= bus.carry_in;
            cnt    <= '0;
        end else if (shift_en) begin
            // Result bits enter at the MSB so after WIDTH shifts the first
            // (LSB) bit has arrived at position 0.
            res_sr <= {fa_sum, res_sr[WIDTH-1:1]};
            a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
            c_ff   <= fa_cout;
            cnt    <= cnt + 1'b1;
        end
    end

    // Result registers: updated only on the final bit so the visible result
    // stays stable throughout the next operation's shift phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (last_bit) begin
            sum_q  <= {fa_sum, res_sr[WIDTH-1:1]};
            cout_q <= fa_cout;
        end
    end

    assign bus.busy      = (state == ST_SHIFT);
    assign bus.done      = (state == ST_DONE);
    assign bus.sum       = sum_q;
    assign bus.carry_out = cout_q;
    assign bus.state     = state;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboarded bench for serial_adder with WIDTH=8 and directed vectors.
module tb_serial_adder;
    import serial_adder_pkg::*;

    localparam int W = 8;

    logic clk;
    logic rst_n;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [W:0] exp_q[$];
    int n_cmp  = 0;
    int n_err  = 0;
    int n_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                check("result", {23'd0, bus.carry_out, bus.sum}, {23'd0, e});
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a negedge; returns #1 after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic [W:0] exp);
        bus.start    = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.carry_in = cin;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.carry_in = 1'b0;
    endtask

    // Counts negedges until done, also counting cycles with busy high.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (bus.busy) bcnt++;
            if (bus.done) break;
            if (lat > 40) begin
                n_cmp++;
                n_err++;
                $display("FAIL done_timeout: got no done expected done within 40 cycles");
                break;
            end
        end
    endtask

    // Runs a full op and checks latency, busy length and the done pulse width.
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic [W:0] exp);
        int lat, bcnt;
        issue(a, b, cin, exp);
        wait_done(lat, bcnt);
        check({name, "_latency"}, lat, W + 1);
        check({name, "_busy_cycles"}, bcnt, W);
        @(negedge clk);
        check({name, "_done_width"}, {31'd0, bus.done}, 0);
        check({name, "_idle_after"}, {30'd0, bus.state}, {30'd0, ST_IDLE});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat, bcnt, d0;

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.carry_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_busy",  {31'd0, bus.busy}, 0);
        check("rst_done",  {31'd0, bus.done}, 0);
        check("rst_sum",   {24'd0, bus.sum}, 32'h00);
        check("rst_cout",  {31'd0, bus.carry_out}, 0);
        check("rst_state", {30'd0, bus.state}, {30'd0, ST_IDLE});

        run_op("zero",   8'h00, 8'h00, 1'b0, 9'h000);
        run_op("basic",  8'h3C, 8'h42, 1'b0, 9'h07E);
        run_op("wrap",   8'hFF, 8'h01, 1'b0, 9'h100);
        run_op("ripple", 8'hA5, 8'h5A, 1'b1, 9'h100);

        // start pulsed mid-SHIFT must be ignored
        d0 = n_done;
        issue(8'h3C, 8'h42, 1'b0, 9'h07E);
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h11;
        bus.b     = 8'h11;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat, bcnt);
        check("midstart_latency", lat, 6);
        repeat (12) @(negedge clk);
        check("midstart_done_count", n_done - d0, 1);
        check("midstart_busy_after", {31'd0, bus.busy}, 0);

        // back-to-back: start in the DONE cycle
        issue(8'h3C, 8'h42, 1'b0, 9'h07E);
        wait_done(lat, bcnt);
        check("b2b_first_latency", lat, W + 1);
        issue(8'h80, 8'h80, 1'b0, 9'h100);
        check("b2b_no_gap_busy", {31'd0, bus.busy}, 1);
        check("b2b_held_sum", {24'd0, bus.sum}, 32'h7E);
        repeat (4) @(negedge clk);
        check("b2b_held_sum_mid", {24'd0, bus.sum}, 32'h7E);
        check("b2b_held_cout_mid", {31'd0, bus.carry_out}, 0);
        wait_done(lat, bcnt);
        check("b2b_second_latency", lat, W + 1 - 4);
        @(negedge clk);

        // reset in the middle of SHIFT
        d0 = n_done;
        issue(8'h12, 8'h34, 1'b0, 9'h046);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("abort_busy",  {31'd0, bus.busy}, 0);
        check("abort_done",  {31'd0, bus.done}, 0);
        check("abort_sum",   {24'd0, bus.sum}, 32'h00);
        check("abort_cout",  {31'd0, bus.carry_out}, 0);
        check("abort_state", {30'd0, bus.state}, {30'd0, ST_IDLE});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_no_done", n_done - d0, 0);
        run_op("fresh", 8'h0F, 8'h01, 1'b1, 9'h011);

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder that drives the existing full_adder cell one bit per clock, LSB first.
- Adds a carry flip-flop, operand shift registers, a bit counter and a start/done handshake around that single cell.
- Sits directly around full_adder: it produces the cell's x/y/carry_in inputs each cycle and consumes its sum/carry_out.
- Gives the lab datapath a sequential multi-bit adder with minimal area (one full_adder for any WIDTH).

Parameters:
- WIDTH, 8, operand and result width in bits; legal range is 2 to 32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; sampled on the accepted start edge.
- b  input  WIDTH  operand B; sampled on the accepted start edge.
- carry_in  input  1  initial carry; sampled on the accepted start edge.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; sum and carry_out are valid from this cycle on.
- sum  output  WIDTH  registered result of a+b+carry_in, modulo 2^WIDTH.
- carry_out  output  1  registered final carry (bit WIDTH of the full result).

Behaviour:
- Clock/reset: single clock domain. rst_n is asynchronous active-low, applied immediately and released synchronously to clk by the system.
- Reset values: state=IDLE, busy=0, done=0, sum=0, carry_out=0. All internal shift registers, the carry FF and the bit counter are cleared.
- FSM states: IDLE, SHIFT, DONE. Encoding is taken from the shared constants.
- IDLE:
  - start=1 -> load a_sr<=a, b_sr<=b, c_ff<=carry_in, cnt<=0, res_sr<=0, then go to SHIFT.
  - start=0 -> stay in IDLE.
- SHIFT, every cycle:
  - full_adder inputs: x=a_sr[0], y=b_sr[0], carry_in=c_ff.
  - Register updates: res_sr<={fa_sum, res_sr[WIDTH-1:1]}; a_sr and b_sr shift right by 1 with zero fill; c_ff<=fa_cout; cnt<=cnt+1.
- SHIFT exit: on the cycle where cnt==WIDTH-1, after the updates above, go to DONE and register the results: sum<={fa_sum, res_sr[WIDTH-1:1]} and carry_out<=fa_cout.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
  - start=1 in DONE is accepted exactly as in IDLE: load the operands and go straight to SHIFT. This allows back-to-back operations with no idle cycle.
- Latency: start accepted at edge 0 -> busy for edges 1..WIDTH -> done high in the cycle after edge WIDTH. Total is WIDTH+1 cycles from start to done.
- sum and carry_out hold their last result until the next completion; they do not change during SHIFT.
- start while busy (SHIFT) is ignored; the operation in flight is not disturbed and the new operands are not captured.
- a, b and carry_in are don't-care outside the accepted start cycle.
- Counter width is $clog2(WIDTH). cnt never wraps: the block exits SHIFT at WIDTH-1.
- Reset mid-operation (any state): returns to IDLE with all reset values. No done pulse is issued for the aborted operation, and the previous sum is cleared to 0.
- Arithmetic: sum is the unsigned WIDTH-bit result and carry_out the overflow, i.e. {carry_out, sum} == a+b+carry_in.

Decomposition:
- Shared package/header holds:
  - state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
  - the default WIDTH constant.
- One sub-module: exactly one instance of the existing full_adder (ports x, y, carry_in, sum, carry_out), instantiated unmodified.
- Everything else (FSM, shift registers, counter, result registers) stays in serial_adder.

Test Plan (WIDTH=8):
- Reset low 3 cycles, then release -> busy=0, done=0, sum=0x00, carry_out=0. 0x00+0x00+cin 0 -> done at start+9 cycles with sum=0x00, carry_out=0.
- a=0x3C, b=0x42, cin=0 -> sum=0x7E, carry_out=0; busy high exactly 8 cycles; done high exactly 1 cycle.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, carry_out=1. a=0xA5, b=0x5A, cin=1 -> sum=0x00, carry_out=1 (full carry ripple).
- start pulsed mid-SHIFT with a=0x11, b=0x11 during a 0x3C+0x42 operation -> result is still 0x7E/0 and no second done follows.
- start asserted in the DONE cycle with a=0x80, b=0x80, cin=0 -> next op begins with no IDLE gap; its done gives sum=0x00, carry_out=1; the prior result 0x7E stays held until then.
- rst_n pulsed low at SHIFT cycle 4 -> outputs go to reset values immediately; no done pulse; a fresh start then completes correctly.
